// File: rtl/sync_count_monitor_if.sv
// Observed counter bus plus the monitor's verdicts; the counter side is the master,
// the monitor is the slave. Outputs are registered inside the monitor.
interface sync_count_monitor_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic [WIDTH-1:0] q;
  logic             dir;
  logic             locked;
  logic             err;
  logic             wrap;
  logic             dir_chg;
  logic [7:0]       err_cnt;

  modport master (
    output en, q,
    input  dir, locked, err, wrap, dir_chg, err_cnt
  );

  modport slave (
    input  en, q,
    output dir, locked, err, wrap, dir_chg, err_cnt
  );
endinterface

// File: rtl/sync_count_monitor.sv
// Infers direction of a sampled up/down counter, locks on a consistent run, flags jumps/wraps/reversals.
// All outputs registered, one clock after the causing en sample; no backpressure, q is sampled only when en=1.
module sync_count_monitor #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 2
) (
  input logic                 clk,
  input logic                 rst,
  sync_count_monitor_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  localparam logic [2:0]       LP_LOCK = 3'(LOCK_N);
  localparam logic [WIDTH-1:0] LP_MAX  = '1;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_delta;
  logic             r_cand, w_cand;
  logic [2:0]       r_streak, w_streak, w_streak_inc;
  logic             r_dir, w_dir;
  logic             r_locked, w_locked;
  logic             r_err, w_err;
  logic             r_wrap, w_wrap;
  logic             r_chg, w_chg;
  logic [7:0]       r_cnt, w_cnt;
  logic             w_up, w_dn, w_step, w_jump;

  assign w_delta      = bus.q - r_prev;
  assign w_up         = (w_delta == WIDTH'(1));
  assign w_dn         = (w_delta == LP_MAX);
  assign w_step       = w_up | w_dn;
  assign w_jump       = (w_delta != '0) && !w_step;
  assign w_streak_inc = r_streak + 3'd1;

  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_streak = r_streak;
    w_dir    = r_dir;
    w_locked = r_locked;
    w_err    = 1'b0;
    w_wrap   = 1'b0;
    w_chg    = 1'b0;
    w_cnt    = r_cnt;
    if (bus.en) begin
      unique case (r_state)
        S_IDLE: begin
          w_state  = S_ACQ;
          w_streak = '0;
        end
        S_ACQ: begin
          if (w_jump) begin
            w_err    = 1'b1;
            w_streak = '0;
          end else if (w_step) begin
            // An empty streak accepts either direction as the new candidate
            w_cand   = w_up;
            w_streak = (r_streak == '0 || w_up == r_cand) ? w_streak_inc : 3'd1;
            if (w_streak == LP_LOCK) begin
              w_state  = S_LOCK;
              w_dir    = w_up;
              w_locked = 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (w_jump) begin
            w_err    = 1'b1;
            w_locked = 1'b0;
            w_streak = '0;
            w_state  = S_ACQ;
          end else if (w_step) begin
            if (w_up != r_dir) begin
              w_dir = w_up;
              w_chg = 1'b1;
            end
            w_wrap = (w_up && bus.q == '0) || (w_dn && bus.q == LP_MAX);
          end
        end
        default: w_state = S_IDLE;
      endcase
      if (w_err && r_cnt != 8'hFF) w_cnt = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_prev   <= '0;
      r_cand   <= 1'b0;
      r_streak <= '0;
      r_dir    <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_wrap   <= 1'b0;
      r_chg    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_cand   <= w_cand;
      r_streak <= w_streak;
      r_dir    <= w_dir;
      r_locked <= w_locked;
      r_err    <= w_err;
      r_wrap   <= w_wrap;
      r_chg    <= w_chg;
      r_cnt    <= w_cnt;
      if (bus.en) r_prev <= bus.q;
    end
  end

  assign bus.dir     = r_dir;
  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.wrap    = r_wrap;
  assign bus.dir_chg = r_chg;
  assign bus.err_cnt = r_cnt;

endmodule

// File: tb/tb_sync_count_monitor.sv
// Directed plan plus randomized counter traffic, checked every cycle against a run-length model
// of the monitor's rules and pinned by literal expectations.
module tb_sync_count_monitor;
  localparam int LOCK_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   cmp_on = 1'b0;

  sync_count_monitor_if #(.WIDTH(3)) bus ();

  sync_count_monitor #(.WIDTH(3), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: run = signed count of consecutive steps (+ up, - down)
  bit         m_have;
  logic [2:0] m_prev;
  int         m_run;
  logic       e_dir, e_locked, e_err, e_wrap, e_chg;
  logic [7:0] e_cnt;

  always @(posedge clk or negedge rst) begin
    int d, s;
    if (!rst) begin
      m_have = 0; m_prev = '0; m_run = 0;
      e_dir = 0; e_locked = 0; e_err = 0; e_wrap = 0; e_chg = 0; e_cnt = '0;
    end else begin
      e_err = 0; e_wrap = 0; e_chg = 0;
      if (bus.en) begin
        if (!m_have) begin
          m_have = 1;
        end else begin
          d = (int'(bus.q) - int'(m_prev) + 8) % 8;
          s = (d == 1) ? 1 : (d == 7) ? -1 : (d == 0) ? 0 : 2;
          if (s == 2) begin
            e_err = 1;
            if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
            e_locked = 0;
            m_run = 0;
          end else if (s != 0) begin
            if (e_locked) begin
              if ((s > 0) != e_dir) begin
                e_dir = (s > 0);
                e_chg = 1;
              end
              if ((s > 0 && m_prev == 3'd7) || (s < 0 && m_prev == 3'd0)) e_wrap = 1;
            end else begin
              if (m_run == 0 || ((m_run > 0) == (s > 0))) m_run = m_run + s;
              else m_run = s;
              if (m_run >= LOCK_N || -m_run >= LOCK_N) begin
                e_locked = 1;
                e_dir = (s > 0);
              end
            end
          end
        end
        m_prev = bus.q;
      end
    end
  end

  function automatic logic [12:0] dut_vec();
    return {bus.dir, bus.locked, bus.err, bus.wrap, bus.dir_chg, bus.err_cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on && rst)
      chk("model", 32'(dut_vec()), 32'({e_dir, e_locked, e_err, e_wrap, e_chg, e_cnt}));
  end

  task automatic smp(input logic e, input logic [2:0] v);
    @(negedge clk);
    bus.en = e;
    bus.q  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rel();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rel();
  endtask

  initial begin
    logic [2:0] rq;
    logic       rdir;
    int         r;
    bus.en = 1'b0;
    bus.q  = '0;

    // Reset and first capture
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rel();
    cmp_on = 1'b1;
    smp(1, 3'd5);
    chk("capture_no_err", 32'(bus.err), 32'd0);
    chk("capture_outputs", 32'(dut_vec()), 32'd0);

    // Up-count lock and wrap
    do_reset();
    smp(1, 3'd0);
    smp(1, 3'd1);
    chk("not_locked_yet", 32'(bus.locked), 32'd0);
    smp(1, 3'd2);
    chk("lock_up", 32'({bus.locked, bus.dir}), 32'b11);
    for (int i = 3; i < 8; i++) smp(1, 3'(i));
    chk("no_wrap_at_7", 32'(bus.wrap), 32'd0);
    smp(1, 3'd0);
    chk("wrap_up", 32'({bus.wrap, bus.dir_chg, bus.locked}), 32'b101);

    // Reversal across the boundary
    smp(1, 3'd7);
    chk("rev_pulses", 32'({bus.dir_chg, bus.wrap, bus.dir, bus.locked}), 32'b1101);
    smp(1, 3'd6);
    chk("rev_settled", 32'({bus.dir_chg, bus.dir, bus.locked}), 32'b001);
    smp(1, 3'd5);
    smp(1, 3'd6);
    chk("rev_back_up", 32'({bus.dir_chg, bus.dir}), 32'b11);

    // Illegal jump from locked-up at 3, then relock
    smp(1, 3'd7); smp(1, 3'd0); smp(1, 3'd1); smp(1, 3'd2); smp(1, 3'd3);
    chk("locked_at_3", 32'({bus.locked, bus.dir}), 32'b11);
    smp(1, 3'd6);
    chk("jump_err", 32'({bus.err, bus.locked, bus.err_cnt}), 32'({1'b1, 1'b0, 8'd1}));
    smp(1, 3'd7);
    chk("after_jump", 32'({bus.err, bus.locked}), 32'b00);
    smp(1, 3'd0);
    chk("relock", 32'({bus.locked, bus.wrap}), 32'b10);

    // Hold and enable gating
    smp(1, 3'd1); smp(1, 3'd2); smp(1, 3'd3); smp(1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      smp(1, 3'd4);
      chk("hold", 32'({bus.dir, bus.locked, bus.err, bus.wrap, bus.dir_chg}), 32'b11000);
    end
    for (int i = 0; i < 6; i++) begin
      smp(0, 3'($urandom));
      chk("en_low", 32'({bus.dir, bus.locked, bus.err, bus.wrap, bus.dir_chg}), 32'b11000);
    end

    // Asynchronous reset mid-lock
    #2 rst = 1'b0;
    #1 chk("async_reset", 32'({bus.locked, bus.dir, bus.err_cnt}), 32'd0);
    rel();

    // Randomized counter traffic with jumps, holds, reversals and gaps
    rq = 3'($urandom);
    rdir = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 3500) do_reset();
      r = $urandom_range(99);
      if ($urandom_range(99) < 4) rdir = ~rdir;
      if (r < 60) rq = rdir ? rq + 3'd1 : rq - 3'd1;
      else if (r >= 68) rq = 3'($urandom);
      if ($urandom_range(9) == 0) smp(0, 3'($urandom));
      else smp(1, rq);
      if (i == 3499) chk("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_count_monitor.md
# sync_count_monitor

Receive-side checker for the 3-bit synchronous up/down counter family. It samples a counter's `q` bus and works out the counting direction from consecutive values. It locks onto a consistent sequence and flags illegal jumps, wrap-arounds and direction changes. It sits downstream of the counter in bring-up and self-check benches, and in designs that must confirm a free-running counter is healthy.

## Interface
- `WIDTH`, default 3: width of the observed count.
- `LOCK_N`, default 2: number of consecutive same-direction steps needed to lock; legal range 1..7.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`  in  1: sample strobe; `q` is evaluated only on edges where `en`=1.
- `q`  in  WIDTH: observed counter value.
- `dir`  out  1: inferred direction, 1 = up, 0 = down (same sense as the counter's mode input `m`).
- `locked`  out  1: a consistent step sequence has been confirmed.
- `err`  out  1: one-cycle pulse on an illegal jump.
- `wrap`  out  1: one-cycle pulse on a locked step across the max↔0 boundary.
- `dir_chg`  out  1: one-cycle pulse when a locked sequence reverses direction.
- `err_cnt`  out  8: saturating count of `err` pulses.

## Operation
- Registers:
  - `prev` (WIDTH bits) holds the last sampled value.
  - `cand` (1 bit) holds the candidate direction.
  - `streak` (3 bits) counts consecutive same-direction steps.
  - A state register holds IDLE, ACQ or LOCK.
- Step classification on each `en` sample, with `delta = (q - prev) mod 2^WIDTH`:
  - `delta == 1` is an UP step.
  - `delta == 2^WIDTH-1` is a DOWN step.
  - `delta == 0` is a HOLD: no effect except `prev` is unchanged.
  - Any other `delta` is a JUMP.
- `prev <= q` on every `en` sample, in every state.
- IDLE: the first `en` sample captures `prev` and moves to ACQ with `streak`=0. No classification is done in IDLE.
- ACQ:
  - A step in the same direction as `cand`, or any step when `streak`=0, sets `cand` to the step direction and increments `streak`.
  - When `streak` reaches `LOCK_N`, the block enters LOCK with `dir <= cand` and `locked <= 1`.
  - A step in the opposite direction sets `cand` to the new direction and `streak` to 1.
  - A JUMP pulses `err` and clears `streak` to 0.
- LOCK:
  - A step in the same direction as `dir` has no effect.
  - A step in the opposite direction flips `dir`, pulses `dir_chg`, and stays locked.
  - A JUMP pulses `err`, clears `locked`, and returns to ACQ with `streak`=0.
  - HOLD has no effect.
- `wrap` is asserted only in LOCK (including the step that causes `dir_chg`):
  - on an UP step from 2^WIDTH-1 to 0;
  - on a DOWN step from 0 to 2^WIDTH-1.
- `err_cnt` increments on each `err` pulse and saturates at 255.
- When `en`=0, all state holds and all pulse outputs are 0.

## Timing
- All outputs are registered. The response appears one clock after the `en` sample that causes it.
- Pulse outputs (`err`, `wrap`, `dir_chg`) are high for exactly one cycle per causing sample.
- With `LOCK_N`=L, `locked` rises one clock after the (L+1)-th consecutive step-consistent sample following reset.
- Reset values:
  - outputs: `dir`=0, `locked`=0, `err`=0, `wrap`=0, `dir_chg`=0, `err_cnt`=0;
  - internal: state IDLE, `prev`=0, `streak`=0, `cand`=0.
- Reset asserted mid-LOCK clears everything immediately (asynchronously). The first sample after release is a capture only; it never raises `err`.
- When `err` and entry to ACQ happen on the same sample, the JUMP value becomes `prev`, so the following step can begin a new streak.

## Test plan
- Reset and capture:
  - Stimulus: `rst`=0 then release; feed `en`=1 with `q`=5.
  - Required: all outputs 0 throughout; no `err` on the first sample.
- Up-count lock and wrap (`LOCK_N`=2):
  - Stimulus: `q` = 0,1,2,…,7,0 on consecutive edges.
  - Required: `locked`=1 and `dir`=1 one clock after sample `q`=2; `wrap` pulses once, one clock after the final `q`=0.
- Mode reversal (continuing from the previous test):
  - Stimulus: `q` = 0 → 7 → 6 → 5.
  - Required: `dir_chg` and `wrap` pulse together one clock after `q`=7; `dir`=0 from then on; `locked` stays 1.
- Illegal jump:
  - Stimulus: while locked up at `q`=3, feed `q`=6.
  - Required: `err` pulses, `locked`=0, `err_cnt`=1. Then `q` = 7,0 relocks (`locked`=1 one clock after `q`=0).
- Hold and enable gating:
  - Stimulus: repeat `q`=4 for 5 samples, then drive `en`=0 with random `q`.
  - Required: no change to `dir`/`locked`; no pulses.
- Reset mid-lock:
  - Stimulus: assert `rst` between clock edges while `locked`=1.
  - Required: `locked`, `dir` and `err_cnt` go to 0 without waiting for `clk`.
